// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection unit for a 5-stage pipeline with
// branches resolved in ID. It decodes memory-wait, load-use and branch-operand
// hazards into stall, bubble, hold and flush controls. It also keeps
// saturating stall and flush counters and a sticky watchdog for long stalls.
module hazard_ctrl #(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic             branch_taken,
   input  logic             idex_memread,
   input  logic             idex_regwrite,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_memread,
   input  logic [4:0]       exmem_rd,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             hazard_err
);

   localparam int RL_W = $clog2(MAX_STALL + 1);
   localparam logic [RL_W-1:0] MAX_RL = RL_W'(MAX_STALL);

   typedef enum logic [1:0] {RUN, STALL, MEMWAIT} state_t;

   state_t          state;
   state_t          next_state;
   logic [RL_W-1:0] run_len;
   logic [RL_W-1:0] run_len_nxt;
   logic            memw;
   logic            lu;
   logic            brh;

   // A producer register matches the ID instruction when it is a real register
   // (r0 never carries a dependency) and it feeds rs, or rt when rt is read.
   function automatic logic match(input logic [4:0] r,
                                  input logic [4:0] rs,
                                  input logic [4:0] rt,
                                  input logic       uses_rt);
      return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

   assign memw = mem_busy;
   assign lu   = idex_memread && match(idex_rt, id_rs, id_rt, id_uses_rt);
   assign brh  = id_is_branch &&
                 ((idex_regwrite && match(idex_rd, id_rs, id_rt, id_uses_rt)) ||
                  (exmem_memread && match(exmem_rd, id_rs, id_rt, id_uses_rt)));

   // Prioritised hazard decode: pipeline controls and next FSM state
   always_comb begin
      // NOTE: every output gets a default before any branch so no path infers a latch.
      next_state  = RUN;
      pc_write    = 1'b1;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      if (!rst_n) begin
         // While in reset, keep the PC still and squash whatever sits in IF/ID.
         pc_write   = 1'b0;
         ifid_flush = 1'b1;
      end else if (memw) begin
         next_state = MEMWAIT;
         pc_write   = 1'b0;
         ifid_stall = 1'b1;
         pipe_hold  = 1'b1;
      end else if (lu || brh) begin
         next_state  = STALL;
         pc_write    = 1'b0;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
      end else if (id_is_branch && branch_taken) begin
         ifid_flush = 1'b1;
      end
   end

   // Length of the current stall episode, which counts from 1 when it leaves RUN
   // and saturates at the watchdog limit.
   always_comb begin
      run_len_nxt = '0;
      if (next_state != RUN) begin
         if (state == RUN)
            run_len_nxt = RL_W'(1);
         else if (run_len == MAX_RL)
            run_len_nxt = run_len;
         else
            run_len_nxt = run_len + RL_W'(1);
      end
   end

   // State, stall-run length, sticky watchdog and saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments, and the async reset sits in
      // the sensitivity list so clearing does not wait for a clock edge.
      if (!rst_n) begin
         state      <= RUN;
         run_len    <= '0;
         hazard_err <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         state   <= next_state;
         run_len <= run_len_nxt;
         if (run_len_nxt == MAX_RL)
            hazard_err <= 1'b1;
         if (ifid_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed tests for hazard_ctrl. The outputs are compared as
// the vector {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold}.
module tb_hazard_ctrl;

   localparam int CNT_W = 16;

   localparam logic [4:0] O_RUN   = 5'b10000;
   localparam logic [4:0] O_STALL = 5'b01010;
   localparam logic [4:0] O_FLUSH = 5'b10100;
   localparam logic [4:0] O_HOLD  = 5'b01001;
   localparam logic [4:0] O_RST   = 5'b00100;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_rs, id_rt, idex_rd, idex_rt, exmem_rd;
   logic             id_uses_rt, id_is_branch, branch_taken;
   logic             idex_memread, idex_regwrite, exmem_memread, mem_busy;
   logic             pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             hazard_err;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .branch_taken(branch_taken),
      .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
      .idex_rd(idex_rd), .idex_rt(idex_rt),
      .exmem_memread(exmem_memread), .exmem_rd(exmem_rd),
      .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hazard_err(hazard_err)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      id_is_branch = 1'b0; branch_taken = 1'b0;
      idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0; idex_rt = 5'd0;
      exmem_memread = 1'b0; exmem_rd = 5'd0; mem_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      n_checks++;
      if (outs() !== O_RST) begin
         n_fail++;
         $display("FAIL reset_outs: got %b expected %b", outs(), O_RST);
      end
      n_checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_cnts: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
      end
      n_checks++;
      if (hazard_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b expected 0", hazard_err);
      end
      step();
      #2 rst_n = 1'b1;
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL idle_outs: got %b expected %b", outs(), O_RUN);
      end
      step();
   endtask

   task automatic test_load_use();
      idle_inputs();
      idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL lu_outs: got %b expected %b", outs(), O_STALL);
      end
      step(); exp_stall++;
      idle_inputs();
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL lu_after: got %b expected %b", outs(), O_RUN);
      end
      step();
      n_checks++;
      if (stall_cnt !== CNT_W'(exp_stall)) begin
         n_fail++;
         $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_operand_match();
      // r0 never creates a dependency
      idle_inputs();
      idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL zero_reg: got %b expected %b", outs(), O_RUN);
      end
      step();
      // rt matches but the instruction does not read rt
      idex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL rt_unused: got %b expected %b", outs(), O_RUN);
      end
      step();
      id_uses_rt = 1'b1;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL rt_used: got %b expected %b", outs(), O_STALL);
      end
      step(); exp_stall++;
      // A non-branch ALU dependency is handled by forwarding, not stalls
      idle_inputs();
      idex_regwrite = 1'b1; idex_rd = 5'd9; id_rs = 5'd9;
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL alu_no_stall: got %b expected %b", outs(), O_RUN);
      end
      step();
      n_checks++;
      if (stall_cnt !== CNT_W'(exp_stall)) begin
         n_fail++;
         $display("FAIL match_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      id_is_branch = 1'b1; branch_taken = 1'b1;
      idex_regwrite = 1'b1; idex_rd = 5'd3; id_rs = 5'd3;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL brh_outs: got %b expected %b", outs(), O_STALL);
      end
      step(); exp_stall++;
      idex_regwrite = 1'b0;
      #1;
      n_checks++;
      if (outs() !== O_FLUSH) begin
         n_fail++;
         $display("FAIL taken_flush: got %b expected %b", outs(), O_FLUSH);
      end
      step(); exp_flush++;
      n_checks++;
      if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
         n_fail++;
         $display("FAIL brh_cnts: got stall=%0d flush=%0d expected %0d/%0d",
                  stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      // Branch waiting on a load in EX/MEM
      exmem_memread = 1'b1; exmem_rd = 5'd3;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL brh_exmem: got %b expected %b", outs(), O_STALL);
      end
      step(); exp_stall++;
      idle_inputs();
      step();
   endtask

   task automatic test_priority();
      idle_inputs();
      mem_busy = 1'b1; idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
      #1;
      n_checks++;
      if (outs() !== O_HOLD) begin
         n_fail++;
         $display("FAIL memw_over_lu: got %b expected %b", outs(), O_HOLD);
      end
      step(); exp_stall++;
      mem_busy = 1'b0;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL lu_after_memw: got %b expected %b", outs(), O_STALL);
      end
      step(); exp_stall++;
      idle_inputs();
      step();
      n_checks++;
      if (stall_cnt !== CNT_W'(exp_stall)) begin
         n_fail++;
         $display("FAIL prio_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_watchdog();
      idle_inputs();
      mem_busy = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(); exp_stall++;
      end
      n_checks++;
      if (hazard_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_early: got %b expected 0 after 7 edges", hazard_err);
      end
      step(); exp_stall++;
      n_checks++;
      if (hazard_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_fire: got %b expected 1 after 8 edges", hazard_err);
      end
      mem_busy = 1'b0;
      #1;
      n_checks++;
      if (outs() !== O_RUN) begin
         n_fail++;
         $display("FAIL wd_outs: got %b expected %b", outs(), O_RUN);
      end
      step(); step();
      n_checks++;
      if (hazard_err !== 1'b1 || stall_cnt !== CNT_W'(exp_stall)) begin
         n_fail++;
         $display("FAIL wd_sticky: got err=%b stall=%0d expected 1/%0d",
                  hazard_err, stall_cnt, exp_stall);
      end
   endtask

   task automatic test_async_reset();
      idle_inputs();
      mem_busy = 1'b1;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0 || hazard_err !== 1'b0) begin
         n_fail++;
         $display("FAIL async_state: got stall=%0d flush=%0d err=%b expected 0/0/0",
                  stall_cnt, flush_cnt, hazard_err);
      end
      n_checks++;
      if (outs() !== O_RST) begin
         n_fail++;
         $display("FAIL async_outs: got %b expected %b", outs(), O_RST);
      end
      mem_busy = 1'b0;
      step();
      #2 rst_n = 1'b1;
      step();
      // Back in RUN: a fresh load-use stalls exactly one cycle from zero counts
      idex_memread = 1'b1; idex_rt = 5'd6; id_rs = 5'd6;
      #1;
      n_checks++;
      if (outs() !== O_STALL) begin
         n_fail++;
         $display("FAIL post_rst_lu: got %b expected %b", outs(), O_STALL);
      end
      step();
      idle_inputs();
      step();
      n_checks++;
      if (stall_cnt !== CNT_W'(1) || hazard_err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst_cnt: got stall=%0d err=%b expected 1/0", stall_cnt, hazard_err);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_operand_match();
      test_branch();
      test_priority();
      test_watchdog();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturating performance counters.
REQ-002 SHALL have parameter MAX_STALL, default 8: consecutive-stall limit before the watchdog fires.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port id_rs, input, 5: rs field of the instruction in IF/ID.
REQ-006 SHALL have port id_rt, input, 5: rt field of the instruction in IF/ID.
REQ-007 SHALL have port id_uses_rt, input, 1: the ID instruction reads rt.
REQ-008 SHALL have port id_is_branch, input, 1: the ID instruction is a branch resolved in ID.
REQ-009 SHALL have port branch_taken, input, 1: ID comparator result.
REQ-010 SHALL have ports idex_memread (1), idex_regwrite (1), idex_rd (5) and idex_rt (5), inputs: ID/EX control and destination fields.
REQ-011 SHALL have ports exmem_memread (1) and exmem_rd (5), inputs: EX/MEM load and destination.
REQ-012 SHALL have port mem_busy, input, 1: data memory wait request.
REQ-013 SHALL have port pc_write, output, 1: PC update enable.
REQ-014 SHALL have port ifid_stall, output, 1: drives the IF/ID stall input.
REQ-015 SHALL have port ifid_flush, output, 1: drives the IF/ID ifFlush input.
REQ-016 SHALL have port idex_bubble, output, 1: zeroes ID/EX control signals.
REQ-017 SHALL have port pipe_hold, output, 1: freezes ID/EX, EX/MEM and MEM/WB.
REQ-018 SHALL have ports stall_cnt and flush_cnt, outputs, CNT_W: total stall cycles and total flush cycles.
REQ-019 SHALL have port hazard_err, output, 1: sticky watchdog flag.

Function
REQ-020 SHALL define match(r) as r != 0 && (r == id_rs || (id_uses_rt && r == id_rt)).
REQ-021 SHALL set MEMW when mem_busy = 1.
REQ-022 SHALL set LU when idex_memread = 1 && match(idex_rt).
REQ-023 SHALL set BRH when id_is_branch = 1 && ((idex_regwrite = 1 && match(idex_rd)) || (exmem_memread = 1 && match(exmem_rd))).
REQ-024 SHALL resolve conditions combinationally, same cycle, with priority MEMW > LU > BRH > taken-branch.
REQ-025 SHALL, on MEMW, drive pc_write=0, ifid_stall=1, pipe_hold=1, idex_bubble=0 and ifid_flush=0.
REQ-026 SHALL, on LU or BRH without MEMW, drive pc_write=0, ifid_stall=1, idex_bubble=1, pipe_hold=0 and ifid_flush=0.
REQ-027 SHALL, on id_is_branch && branch_taken with no MEMW, LU or BRH, drive ifid_flush=1 and pc_write=1, with all other outputs 0.
REQ-028 SHALL otherwise drive pc_write=1, with ifid_stall, ifid_flush, idex_bubble and pipe_hold all 0.
REQ-029 SHALL never assert ifid_flush and ifid_stall in the same cycle.
REQ-030 SHALL implement a registered FSM with states RUN, STALL and MEMWAIT; next state is MEMWAIT on MEMW, else STALL on LU or BRH, else RUN.
REQ-031 SHALL hold a consecutive-stall counter run_len: cleared in RUN, incremented each cycle the next state is STALL or MEMWAIT, saturating at MAX_STALL.
REQ-032 SHALL set hazard_err=1 on the edge where run_len reaches MAX_STALL; it stays set until reset.
REQ-033 SHALL increment stall_cnt on every cycle ifid_stall=1, saturating at all-ones (no wrap).
REQ-034 SHALL increment flush_cnt on every cycle ifid_flush=1, saturating at all-ones.
REQ-035 SHALL leave outputs unaffected by hazard_err; the flag is observe-only.

Reset
REQ-036 SHALL, while rst_n=0 and independent of clk, force state=RUN, run_len=0, stall_cnt=0, flush_cnt=0 and hazard_err=0.
REQ-037 SHALL, during reset, drive pc_write=0 and ifid_flush=1, with ifid_stall, idex_bubble and pipe_hold at 0.
REQ-038 SHALL discard any hazard in progress when reset asserts mid-stall; after rst_n rises, the first edge starts in RUN.

Verification
REQ-039 Load-use: idex_memread=1, idex_rt=5, id_rs=5 for 1 cycle -> pc_write=0, ifid_stall=1, idex_bubble=1; next cycle RUN; stall_cnt=1.
REQ-040 Zero register: idex_memread=1, idex_rt=0, id_rs=0 -> no stall, pc_write=1.
REQ-041 Taken branch with BRH: id_is_branch=1, branch_taken=1, idex_regwrite=1, idex_rd=3, id_rs=3 -> stall 1 cycle, no flush; then idex_regwrite=0 -> ifid_flush=1, flush_cnt=1.
REQ-042 Priority: mem_busy=1 with an LU condition -> pipe_hold=1, idex_bubble=0; after mem_busy drops -> 1 LU stall cycle.
REQ-043 Watchdog: mem_busy=1 for 8 cycles with MAX_STALL=8 -> hazard_err=1 after the 8th edge; it stays 1 after mem_busy=0.
REQ-044 Async reset mid-MEMWAIT: rst_n=0 between edges -> counters, run_len and hazard_err read 0 immediately, pc_write=0, ifid_flush=1.
